coin_intake: RTL and testbench
==============================

# coin_intake

Front-end stage of the vending machine: converts the raw, bouncy coin-slot sensor lines into clean, one-coin-per-transfer value words on the 4-bit `data` bus that `vending_mcn` consumes. Each sensor line passes through synchronisation and debounce logic. A rising debounced edge is one inserted coin. Its value is queued in a small FIFO and presented downstream with a valid/ready handshake, so coins inserted while the machine is busy are not lost.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 4: consecutive stable cycles needed to accept a level change; legal range 2–15.
- `FIFO_DEPTH`, 4: coin queue entries; power of two, 2–8.
- `COIN_A_VAL`, 5: 4-bit value reported for slot A.
- `COIN_B_VAL`, 10: 4-bit value reported for slot B.

Ports:
- `clk`, in, 1: the only clock; all state changes on the rising edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `coin_a`, in, 1: raw slot-A sensor, asynchronous, may bounce.
- `coin_b`, in, 1: raw slot-B sensor, asynchronous, may bounce.
- `data_ready`, in, 1: downstream accepts the head coin this cycle.
- `data`, out, 4: head coin value; 0 when the queue is empty.
- `data_valid`, out, 1: queue non-empty.
- `overflow`, out, 1: sticky flag, set when a coin is dropped because the queue is full.
- `count`, out, $clog2(FIFO_DEPTH)+1: queued coins.

## Operation
- **Reset values.** While `rst`=0, regardless of clock:
  - `data`=0, `data_valid`=0, `overflow`=0, `count`=0.
  - Synchronisers, debounced levels and debounce counters are all 0.
  - FIFO pointers are 0.
- **Synchroniser.** Each raw input passes through a 2-flop synchroniser, giving `s2`.
- **Debounce (per slot).**
  - The counter is cleared whenever `s2` equals the debounced level `deb`.
  - Otherwise the counter increments.
  - When the counter would reach `DEBOUNCE_CYCLES`, `deb` takes `s2` and the counter clears.
  - A glitch shorter than `DEBOUNCE_CYCLES` cycles never changes `deb`.
- **Coin event.** A slot's event is the cycle in which its `deb` goes 0→1. Falling transitions produce nothing.
- **Simultaneous A and B events.**
  - A is pushed in that cycle.
  - B is held in a 1-bit pending register and pushed in the next cycle.
  - Because `DEBOUNCE_CYCLES`≥2, a pending B is always drained before the next B event can occur.
- **Push.** Writes the slot value into the FIFO.
  - If the FIFO is full and no pop occurs in the same cycle, the coin is dropped and `overflow` is set; it stays set until reset.
  - If the FIFO is full and a pop occurs in the same cycle, the push is accepted.
- **Pop.** Happens when `data_valid`=1 and `data_ready`=1; the head advances.
- **Empty FIFO.** `data_ready` is ignored when the queue is empty.
- **Pointer wrap.** Pointers wrap modulo `FIFO_DEPTH`.
- **Full/empty detection.** Uses the extra pointer MSB, or `count`.
- **Output encoding.** `data` = head value when `data_valid`=1, else 0. Downstream therefore sees 0 meaning "no coin".
- **Reset mid-operation.** Queued coins, pending B and partial debounce counts are discarded. No coin is emitted after reset until a fresh debounced edge occurs.

## Timing
- **Latency.** Let edge k be the first clock edge that samples a clean `coin_a` high.
  - `deb` rises and the push occurs at edge k+1+`DEBOUNCE_CYCLES`.
  - `data_valid`/`data` are updated after that same edge: `DEBOUNCE_CYCLES`+2 edges in total, i.e. 6 with the defaults.
  - A pending B appears one edge later than A.
- **Registered outputs.** `data`, `data_valid`, `count` and `overflow` are all registered, with no combinational path from inputs.
- **Throughput.** One pop per cycle; at most one push per cycle.
- **Count update.** `count` updates on the same edge as the push or pop. A simultaneous push and pop leaves it unchanged.

## Structure
- **Shared package** `vending_pkg`:
  - coin value constants (`COIN_A_VAL`, `COIN_B_VAL`);
  - the data width (4), shared with `vending_mcn`.
- **Sub-module** `coin_debounce`: one instance per slot, containing the synchroniser, counter and `deb` register, with a `rise` output.
- **FIFO:** kept inline as a register array.

## Test plan
- **Reset.** Hold `rst`=0 with coin lines toggling → all outputs 0. After release, no `data_valid` without a new coin.
- **Single coin A.** Clean `coin_a` high for 10 cycles with `data_ready`=1:
  - `data`=5 and `data_valid`=1 for exactly one cycle, 6 edges after the first high sample;
  - then `data`=0.
- **Bounce rejection.** `coin_b` pulses 3 cycles high, 1 low, 3 high, then stays high → exactly one coin, `data`=10. A lone 3-cycle pulse yields no coin.
- **Simultaneous coins.** `coin_a` and `coin_b` rise on the same cycle with `data_ready`=1 → `data`=5 on one cycle, `data`=10 on the next.
- **Overflow.** `data_ready`=0, insert 5 coins A → `count`=4, `overflow`=1, queue holds 5,5,5,5. Then `data_ready`=1 → four cycles of `data`=5, then `data_valid`=0; `overflow` stays 1.
- **Full with simultaneous pop.** Queue full and `data_ready`=1 on the cycle a new coin B pushes → push accepted, `count` stays 4, `overflow` stays 0, last drained value is 10.

Source files
------------

// File: rtl/vending_pkg.sv
// Definitions shared by the vending machine blocks: the coin data width and
// the default coin values reported on the data bus.
package vending_pkg;

    localparam int DATA_W    = 4;
    localparam int DEB_CNT_W = 4;

    localparam logic [DATA_W-1:0] COIN_A_VAL = 4'd5;
    localparam logic [DATA_W-1:0] COIN_B_VAL = 4'd10;

endpackage

// File: rtl/coin_debounce.sv
// One coin slot: 2-flop synchroniser, stability counter and debounced level.
// The rise output is combinational so that the push lands on the edge where
// the debounced level goes high.
module coin_debounce
    import vending_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic rise
);

    localparam logic [DEB_CNT_W-1:0] LAST_C = DEB_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic                 s1_r;
    logic                 s2_r;
    logic                 deb_r;
    logic [DEB_CNT_W-1:0] cnt_r;
    logic                 hit_s;

    // The level has differed for DEBOUNCE_CYCLES-1 cycles and still differs.
    assign hit_s = (s2_r != deb_r) && (cnt_r == LAST_C);
    assign rise  = hit_s & s2_r;

    // Synchroniser, stability counter and debounced level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_r  <= 1'b0;
            s2_r  <= 1'b0;
            deb_r <= 1'b0;
            cnt_r <= '0;
        end else begin
            s1_r <= raw;
            s2_r <= s1_r;
            if (s2_r == deb_r) begin
                cnt_r <= '0;
            end else if (hit_s) begin
                deb_r <= s2_r;
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + DEB_CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/coin_intake.sv
// Coin-slot front end: debounces both sensors, turns each debounced rising
// edge into one coin word and queues it for vending_mcn behind valid/ready.
module coin_intake #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int FIFO_DEPTH      = 4,
    parameter logic [vending_pkg::DATA_W-1:0] COIN_A_VAL = vending_pkg::COIN_A_VAL,
    parameter logic [vending_pkg::DATA_W-1:0] COIN_B_VAL = vending_pkg::COIN_B_VAL
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            coin_a,
    input  logic                            coin_b,
    input  logic                            data_ready,
    output logic [vending_pkg::DATA_W-1:0]  data,
    output logic                            data_valid,
    output logic                            overflow,
    output logic [$clog2(FIFO_DEPTH):0]     count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int DW = vending_pkg::DATA_W;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    logic          rise_a_s;
    logic          rise_b_s;
    logic          pend_b_r;
    logic          pend_b_nxt_s;
    logic          push_s;
    logic [DW-1:0] push_val_s;
    logic          pop_s;
    logic          full_s;
    logic          accept_s;
    logic [CW-1:0] wr_ptr_r;
    logic [CW-1:0] rd_ptr_r;
    logic [CW-1:0] rd_ptr_nxt_s;
    logic [CW-1:0] count_r;
    logic [CW-1:0] count_nxt_s;
    logic [CW-1:0] remain_s;
    logic [DW-1:0] mem_r [FIFO_DEPTH];
    logic [DW-1:0] data_r;
    logic [DW-1:0] data_nxt_s;
    logic          valid_r;
    logic          overflow_r;

    coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
        .clk  (clk),
        .rst  (rst),
        .raw  (coin_a),
        .rise (rise_a_s)
    );

    coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
        .clk  (clk),
        .rst  (rst),
        .raw  (coin_b),
        .rise (rise_b_s)
    );

    // Push arbitration: A wins a tie, B waits one cycle in the pending flag.
    always_comb begin
        push_s       = 1'b0;
        push_val_s   = '0;
        pend_b_nxt_s = pend_b_r;
        if (rise_a_s) begin
            push_s     = 1'b1;
            push_val_s = COIN_A_VAL;
            if (rise_b_s) begin
                pend_b_nxt_s = 1'b1;
            end else begin
                pend_b_nxt_s = pend_b_r;
            end
        end else if (pend_b_r) begin
            push_s       = 1'b1;
            push_val_s   = COIN_B_VAL;
            pend_b_nxt_s = rise_b_s;
        end else if (rise_b_s) begin
            push_s     = 1'b1;
            push_val_s = COIN_B_VAL;
        end else begin
            push_s = 1'b0;
        end
    end

    assign pop_s    = valid_r & data_ready;
    assign full_s   = (count_r == DEPTH_C);
    assign accept_s = push_s & (~full_s | pop_s);

    // Next pointers, occupancy and head word; a push into a queue that is
    // empty after this cycle's pop becomes the head directly.
    always_comb begin
        rd_ptr_nxt_s = rd_ptr_r;
        count_nxt_s  = count_r;
        remain_s     = count_r - CW'(pop_s);
        data_nxt_s   = '0;
        if (pop_s) begin
            rd_ptr_nxt_s = rd_ptr_r + CW'(1);
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end
        count_nxt_s = remain_s + CW'(accept_s);
        if (count_nxt_s == '0) begin
            data_nxt_s = '0;
        end else if (remain_s == '0) begin
            data_nxt_s = push_val_s;
        end else begin
            data_nxt_s = mem_r[rd_ptr_nxt_s[AW-1:0]];
        end
    end

    // Queue storage, pointers and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_b_r   <= 1'b0;
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= '0;
            data_r     <= '0;
            valid_r    <= 1'b0;
            overflow_r <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            pend_b_r   <= pend_b_nxt_s;
            rd_ptr_r   <= rd_ptr_nxt_s;
            count_r    <= count_nxt_s;
            data_r     <= data_nxt_s;
            valid_r    <= (count_nxt_s != '0);
            overflow_r <= overflow_r | (push_s & full_s & ~pop_s);
            if (accept_s) begin
                mem_r[wr_ptr_r[AW-1:0]] <= push_val_s;
                wr_ptr_r                <= wr_ptr_r + CW'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
        end
    end

    assign data       = data_r;
    assign data_valid = valid_r;
    assign overflow   = overflow_r;
    assign count      = count_r;

endmodule

// File: tb/tb_coin_intake.sv
// Bench for coin_intake: directed scenarios plus random bouncy coin lines,
// checked every cycle against a window-based debounce and queue model.
module tb_coin_intake;

    localparam int D     = 4;
    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          coin_a;
    logic          coin_b;
    logic          data_ready;
    logic [3:0]    data;
    logic          data_valid;
    logic          overflow;
    logic [CW-1:0] count;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    bit hist_a[$];
    bit hist_b[$];
    bit deb_a, deb_b, pend_m, ovf_m;
    int q[$];

    always #5 clk = ~clk;

    coin_intake #(
        .DEBOUNCE_CYCLES (D),
        .FIFO_DEPTH      (DEPTH),
        .COIN_A_VAL      (4'd5),
        .COIN_B_VAL      (4'd10)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .coin_a     (coin_a),
        .coin_b     (coin_b),
        .data_ready (data_ready),
        .data       (data),
        .data_valid (data_valid),
        .overflow   (overflow),
        .count      (count)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Raw samples seen at edges n-1-D .. n-2 all equal v (hist[0] is edge n-1).
    function automatic bit win_all(input bit h[$], input bit v);
        for (int i = 1; i <= D; i++) begin
            if (h[i] != v) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_reset();
        hist_a.delete();
        hist_b.delete();
        for (int i = 0; i < D + 2; i++) begin
            hist_a.push_back(1'b0);
            hist_b.push_back(1'b0);
        end
        deb_a  = 1'b0;
        deb_b  = 1'b0;
        pend_m = 1'b0;
        ovf_m  = 1'b0;
        q.delete();
    endtask

    task automatic model_edge();
        bit pop, ev_a, ev_b, push;
        int val;
        pop  = (q.size() > 0) && data_ready;
        ev_a = 1'b0;
        ev_b = 1'b0;
        if (win_all(hist_a, !deb_a)) begin
            deb_a = !deb_a;
            ev_a  = deb_a;
        end
        if (win_all(hist_b, !deb_b)) begin
            deb_b = !deb_b;
            ev_b  = deb_b;
        end
        push = 1'b0;
        val  = 0;
        if (ev_a) begin
            push = 1'b1; val = 5;
            if (ev_b) pend_m = 1'b1;
        end else if (pend_m) begin
            push = 1'b1; val = 10; pend_m = ev_b;
        end else if (ev_b) begin
            push = 1'b1; val = 10;
        end
        hist_a.push_front(coin_a);
        hist_b.push_front(coin_b);
        void'(hist_a.pop_back());
        void'(hist_b.pop_back());
        if (pop) void'(q.pop_front());
        if (push) begin
            if (q.size() < DEPTH) q.push_back(val);
            else ovf_m = 1'b1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_eq("data",     data,       (q.size() > 0) ? q[0] : 0);
        check_eq("valid",    data_valid, (q.size() > 0) ? 1 : 0);
        check_eq("count",    count,      q.size());
        check_eq("overflow", overflow,   ovf_m);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            coin_a = i[0];
            coin_b = ~i[0];
            @(posedge clk);
            #1;
            check_eq("rst_data",  data,       0);
            check_eq("rst_valid", data_valid, 0);
            check_eq("rst_ovf",   overflow,   0);
            check_eq("rst_count", count,      0);
        end
        coin_a = 1'b0;
        coin_b = 1'b0;
        model_reset();
        rst = 1'b1;
    endtask

    // A single clean coin on one line, held for `hi` cycles then released.
    task automatic coin_pulse(input bit slot_b, input int hi, input int lo);
        if (slot_b) coin_b = 1'b1; else coin_a = 1'b1;
        steps(hi);
        if (slot_b) coin_b = 1'b0; else coin_a = 1'b0;
        steps(lo);
    endtask

    initial begin
        int n, first, second, last, ha, hb;
        rst        = 1'b1;
        coin_a     = 1'b0;
        coin_b     = 1'b0;
        data_ready = 1'b0;
        model_reset();
        @(negedge clk);
        do_reset();
        steps(8);

        // Single coin A: visible exactly on the 6th edge after first high sample
        data_ready = 1'b1;
        coin_a     = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step();
            check_eq("a_lat_valid", data_valid, (i == 6) ? 1 : 0);
            check_eq("a_lat_data",  data,       (i == 6) ? 5 : 0);
        end
        coin_a = 1'b0;
        steps(8);

        // Bounce: 3 high, 1 low, 3 high, stays high -> one coin of 10
        n = 0;
        for (int i = 0; i < 20; i++) begin
            coin_b = (i < 3 || i >= 4) ? 1'b1 : 1'b0;
            step();
            if (data_valid && data == 4'd10) n++;
        end
        check_eq("bounce_coins", n, 1);
        coin_b = 1'b0;
        steps(8);
        n = 0;
        for (int i = 0; i < 15; i++) begin
            coin_b = (i < 3) ? 1'b1 : 1'b0;
            step();
            if (data_valid) n++;
        end
        check_eq("glitch_coins", n, 0);

        // Simultaneous A and B: 5 then 10 on consecutive cycles
        n = 0; first = 0; second = 0;
        coin_a = 1'b1;
        coin_b = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            if (data_valid) begin
                if (n == 0) first = data; else second = data;
                n++;
            end
        end
        check_eq("simul_n",      n,      2);
        check_eq("simul_first",  first,  5);
        check_eq("simul_second", second, 10);
        coin_a = 1'b0;
        coin_b = 1'b0;
        steps(8);

        // Overflow: five coins with no drain
        data_ready = 1'b0;
        for (int i = 0; i < 5; i++) coin_pulse(1'b0, 6, 6);
        check_eq("ovf_count", count, 4);
        check_eq("ovf_flag",  overflow, 1);
        check_eq("ovf_head",  data, 5);
        data_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step();
            check_eq("drain_valid", data_valid, (i < 4) ? 1 : 0);
            check_eq("drain_data",  data,       (i < 4) ? 5 : 0);
        end
        check_eq("ovf_sticky", overflow, 1);
        steps(3);
        do_reset();
        steps(4);

        // Full queue with a pop on the very edge that pushes coin B
        data_ready = 1'b0;
        for (int i = 0; i < 4; i++) coin_pulse(1'b0, 6, 6);
        check_eq("full_count", count, 4);
        coin_b = 1'b1;
        steps(5);
        data_ready = 1'b1;
        step();
        check_eq("fullpop_count", count, 4);
        check_eq("fullpop_ovf",   overflow, 0);
        coin_b = 1'b0;
        last = 0;
        for (int i = 0; i < 10; i++) begin
            if (data_valid) last = data;
            step();
        end
        check_eq("fullpop_last", last, 10);
        check_eq("fullpop_empty", data_valid, 0);

        // Random bouncy lines and random back-pressure
        do_reset();
        ha = 0;
        hb = 0;
        for (int i = 0; i < 3000; i++) begin
            if (ha == 0) begin
                coin_a = 1'($urandom_range(0, 1));
                ha = $urandom_range(1, 12);
            end
            if (hb == 0) begin
                coin_b = 1'($urandom_range(0, 1));
                hb = $urandom_range(1, 12);
            end
            ha--;
            hb--;
            data_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        // Reset in the middle of traffic discards everything
        do_reset();
        n = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (data_valid) n++;
        end
        check_eq("post_rst_quiet", n, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
